// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard unit: forwarding selects, load-use bubbles, branch flushes, memory-wait stall FSM.
// Stall/flush/forward outputs are combinational; a memory wait holds the pipe until ready or MEM_TIMEOUT cycles.
module pipeline_hazard_ctrl #(
    parameter int WIDTH       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_addr_d_i,
    input  logic [4:0]  rs2_addr_d_i,
    input  logic [4:0]  rs1_addr_e_i,
    input  logic [4:0]  rs2_addr_e_i,
    input  logic [4:0]  wr_addr_e_i,
    input  logic [4:0]  wr_addr_m_i,
    input  logic [4:0]  wr_addr_w_i,
    input  logic        reg_wr_en_m_i,
    input  logic        reg_wr_en_w_i,
    input  logic        result_src_e_i,
    input  logic        pc_src_e_i,
    input  logic        mem_req_m_i,
    input  logic        mem_ready_i,
    output logic        stall_f_o,
    output logic        stall_d_o,
    output logic        stall_e_o,
    output logic        stall_m_o,
    output logic        flush_d_o,
    output logic        flush_e_o,
    output logic        flush_w_o,
    output logic [1:0]  fwd_a_e_o,
    output logic [1:0]  fwd_b_e_o,
    output logic        timeout_err_o,
    output logic [15:0] stall_cycles_o
);

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_TIMEOUT - 1);

    logic [0:0]    r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout_err;
    logic [15:0]   r_stall_cycles;

    logic [0:0]    w_state;
    logic [CW-1:0] w_wait_cnt;
    logic          w_mem_miss;
    logic          w_mem_stall;
    logic          w_timeout;
    logic          w_load_use;

    // During the reset cycle the outputs are evaluated as if already in RUN.
    assign w_state    = rst_i ? RUN : r_state;
    assign w_wait_cnt = rst_i ? '0  : r_wait_cnt;

    assign w_mem_miss  = mem_req_m_i & ~mem_ready_i;
    assign w_mem_stall = ((w_state == RUN)  & w_mem_miss) |
                         ((w_state == WAIT) & ~mem_ready_i & (w_wait_cnt < LAST_CNT));
    assign w_timeout   = (r_state == WAIT) & ~mem_ready_i & (r_wait_cnt == LAST_CNT);

    assign w_load_use = result_src_e_i & (wr_addr_e_i != 5'd0) &
                        ((wr_addr_e_i == rs1_addr_d_i) | (wr_addr_e_i == rs2_addr_d_i));

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_wr_en_m_i && (wr_addr_m_i != 5'd0) && (wr_addr_m_i == rs))
            return 2'b10;
        else if (reg_wr_en_w_i && (wr_addr_w_i != 5'd0) && (wr_addr_w_i == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a_e_o = fwd_sel(rs1_addr_e_i);
    assign fwd_b_e_o = fwd_sel(rs2_addr_e_i);

    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_w_o = 1'b0;
        if (w_mem_stall) begin
            // Held E stage re-presents any branch/load once memory releases.
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
        end else if (pc_src_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (w_load_use) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_timeout_err  <= 1'b0;
            r_stall_cycles <= 16'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_miss) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ready_i) begin
                        r_state <= RUN;
                    end else if (w_timeout) begin
                        r_state       <= RUN;
                        r_wait_cnt    <= '0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
            if (stall_f_o && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign timeout_err_o  = r_timeout_err;
    assign stall_cycles_o = r_stall_cycles;

endmodule
